// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//
// Shares one SPI master transaction port between up to NUM_REQ requesters
// (for example the front-panel control FSM and a background register
// poller). Arbitration is round-robin with one complete SPI transaction per
// grant. For the granted requester the block latches its command and write
// data, strobes the master, returns the read data and drives the MISO-mux
// target ID.
//
// Parameters:
//   NUM_REQ         number of requesters, 2..4
//   TIMEOUT_CYCLES  watchdog limit in clocks (only with ARB_TIMEOUT_EN)
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a watchdog aborts a stuck START/WAIT after TIMEOUT_CYCLES,
//               pulsing req_done and req_err together with req_rdata = 0.
//   Undefined : no counter; START and WAIT wait forever; req_err stays 0.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   req_valid           per-requester request level, held until req_done
//   req_cmd, req_wdata  flattened 16-bit command / write data per requester
//   req_done, req_err   one-cycle completion / timeout pulse to the grantee
//   req_rdata           read data of the last transaction (held)
//   grant_idx           current or last granted requester
//   arb_busy            high from grant until req_done
//   master_start_tx     one-cycle start strobe to the SPI master
//   master_spi_busy     SPI master busy
//   master_tx_done      SPI master completion pulse
//   master_cmd_packet   latched command of the grantee
//   master_data_wr      latched write data of the grantee
//   master_data_rd      SPI master read data
//   miso_sel_id         MISO-mux slave ID, equals master_cmd_packet[13:11]

module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  input  logic [16*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [15:0]            req_rdata,
  output logic [1:0]             grant_idx,
  output logic                   arb_busy,
  output logic                   master_start_tx,
  input  logic                   master_spi_busy,
  input  logic                   master_tx_done,
  output logic [15:0]            master_cmd_packet,
  output logic [15:0]            master_data_wr,
  input  logic [15:0]            master_data_rd,
  output logic [2:0]             miso_sel_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]         rr_ptr, rr_ptr_next;
  logic [NUM_REQ-1:0] req_done_next, req_err_next;
  logic [15:0]        req_rdata_next;
  logic [1:0]         grant_next;
  logic               arb_busy_next;
  logic               start_next;
  logic [15:0]        cmd_next, wdata_next;
  logic [2:0]         miso_next;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [2:0]         cand;
  logic [15:0]        win_cmd, win_wdata;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               timeout_hit;
  logic               finish_now;
  logic               timed_out;

  // Round-robin scan: offsets 0..NUM_REQ-1 from rr_ptr, wrapped modulo
  // NUM_REQ by a single conditional subtract (NUM_REQ need not be a power
  // of two). The first pending requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  assign win_cmd      = req_cmd[16*win_idx +: 16];
  assign win_wdata    = req_wdata[16*win_idx +: 16];
  assign grant_onehot = NUM_REQ'(1) << grant_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog restarts on every state change and only runs while START or
  // WAIT is being held.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state) || (state == IDLE) || (state == DONE)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Fires in the last counted cycle so the registered req_done lands exactly
  // TIMEOUT_CYCLES clocks after the state was entered.
  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: nothing ever times out. The AND with zero keeps
  // TIMEOUT_CYCLES referenced so both builds share one parameter list.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= 2'd0;
      req_done          <= '0;
      req_err           <= '0;
      req_rdata         <= 16'h0000;
      grant_idx         <= 2'd0;
      arb_busy          <= 1'b0;
      master_start_tx   <= 1'b0;
      master_cmd_packet <= 16'h0000;
      master_data_wr    <= 16'h0000;
      miso_sel_id       <= 3'd0;
    end else begin
      state             <= state_next;
      rr_ptr            <= rr_ptr_next;
      req_done          <= req_done_next;
      req_err           <= req_err_next;
      req_rdata         <= req_rdata_next;
      grant_idx         <= grant_next;
      arb_busy          <= arb_busy_next;
      master_start_tx   <= start_next;
      master_cmd_packet <= cmd_next;
      master_data_wr    <= wdata_next;
      miso_sel_id       <= miso_next;
    end
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each register takes at the coming edge.
  // Latched command/data/ID hold between grants so late MISO data stays
  // routed to the last target.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    req_done_next  = '0;
    req_err_next   = '0;
    req_rdata_next = req_rdata;
    grant_next     = grant_idx;
    arb_busy_next  = arb_busy;
    start_next     = 1'b0;
    cmd_next       = master_cmd_packet;
    wdata_next     = master_data_wr;
    miso_next      = miso_sel_id;
    finish_now     = 1'b0;
    timed_out      = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          cmd_next      = win_cmd;
          wdata_next    = win_wdata;
          miso_next     = win_cmd[13:11];
          grant_next    = win_idx;
          arb_busy_next = 1'b1;
          state_next    = START;
        end
      end
      START: begin
        // Busy may be a leftover from a transfer started before a reset;
        // never strobe until the master reports idle.
        if (!master_spi_busy) begin
          start_next = 1'b1;
          state_next = WAIT;
        end else if (timeout_hit) begin
          finish_now = 1'b1;
          timed_out  = 1'b1;
        end
      end
      WAIT: begin
        if (master_tx_done) begin
          req_rdata_next = master_data_rd;
          finish_now     = 1'b1;
        end else if (timeout_hit) begin
          finish_now = 1'b1;
          timed_out  = 1'b1;
        end
      end
      DONE: begin
        // Gap cycle: the requester drops req_valid on the req_done edge, so
        // skipping arbitration here keeps the stale level from re-granting.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish_now) begin
      req_done_next = grant_onehot;
      if (timed_out) begin
        req_err_next   = grant_onehot;
        req_rdata_next = 16'h0000;
      end
      arb_busy_next = 1'b0;
      rr_ptr_next   = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
      state_next    = DONE;
    end
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares the single SPI master transaction port between up to NUM_REQ requesters, for example the front-panel control FSM and a background register poller.
- Arbitration is round-robin, one complete SPI transaction per grant.
- For the granted transaction it forwards the command and write data, strobes the master, returns the read data to the requester, and drives the MISO-mux target ID.
- Sits between the requesters and the SPI master, replacing their direct wiring to the master.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..4.
- TIMEOUT_CYCLES, 1000000, watchdog limit in clocks; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request level; held until the matching req_done pulse
- req_cmd  in  16*NUM_REQ  flattened command packets; requester i uses bits [16i+15:16i]
- req_wdata  in  16*NUM_REQ  flattened write data, same slicing as req_cmd
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  out  NUM_REQ  one-cycle timeout flag, coincident with req_done; constant 0 without ARB_TIMEOUT_EN
- req_rdata  out  16  read data from the last transaction; valid in the req_done cycle and held afterwards
- grant_idx  out  2  index of the current or last granted requester
- arb_busy  out  1  high from grant until req_done
- master_start_tx  out  1  one-cycle start strobe to the SPI master
- master_spi_busy  in  1  SPI master busy
- master_tx_done  in  1  SPI master completion pulse
- master_cmd_packet  out  16  latched command of the granted requester
- master_data_wr  out  16  latched write data of the granted requester
- master_data_rd  in  16  SPI master read data
- miso_sel_id  out  3  target slave ID for the MISO mux; equals master_cmd_packet[13:11]

Behaviour:
- Reset values: every output is 0; rr_ptr = 0; state = IDLE.
- All outputs are registered.

State machine:
- IDLE
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - On a winner: latch its cmd and wdata into master_cmd_packet and master_data_wr; set grant_idx and miso_sel_id = cmd[13:11]; set arb_busy = 1; go to START.
  - No request: stay in IDLE.
- START
  - If master_spi_busy = 0: master_start_tx = 1 for exactly one cycle; go to WAIT.
  - Otherwise stay in START (no strobe while the master is busy, including when busy is left over from a pre-reset transfer).
- WAIT
  - On master_tx_done: req_rdata <= master_data_rd; req_done[grant_idx] = 1 for one cycle; arb_busy <= 0; rr_ptr <= (grant_idx + 1) mod NUM_REQ; go to DONE.
- DONE
  - One-cycle gap state; no arbitration; go to IDLE.

Timing and handshake:
- Latency: req_valid sampled in IDLE at edge N, so master_cmd_packet is valid after N. The start strobe is high in the cycle after edge N+1 if the master is idle.
- A requester must keep cmd and wdata stable while req_valid is high.
- A requester must drop req_valid on the edge where it samples req_done = 1. The DONE state guarantees it is not re-granted on the stale level.

Boundary conditions:
- Simultaneous requests: the lowest index at or after rr_ptr wins. No requester waits more than NUM_REQ - 1 grants.
- req_valid dropped mid-transaction: the transaction still completes and req_done still pulses.
- Changes to req_cmd or req_wdata after the grant are ignored.
- master_tx_done outside WAIT is ignored.
- Reset mid-transaction: everything returns to reset values immediately. No req_done is issued for the aborted transaction.
- rr_ptr wraps from NUM_REQ-1 to 0. Bits of req_valid at or above NUM_REQ are ignored.
- miso_sel_id holds its value after completion until the next grant, so late MISO data stays routed.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- When defined:
  - A counter runs in START and WAIT and clears on every state entry.
  - If it reaches TIMEOUT_CYCLES without a start or done: req_done and req_err pulse for the granted requester, req_rdata <= 16'h0000, rr_ptr advances, and the block goes to DONE.
- When not defined:
  - No counter is built; START and WAIT wait forever.
  - req_err is tied to 0.

Test Plan:
- Single request: req 0 with cmd 16'h0A2A, wdata 16'h1234, busy = 0 → master_cmd_packet = 16'h0A2A, master_data_wr = 16'h1234, miso_sel_id = 3'd1, exactly one start strobe. On tx_done with rd = 16'hBEEF: req_done[0] pulses and req_rdata = 16'hBEEF.
- Simultaneous requests: all four requesters held continuously → grants occur in order 0, 1, 2, 3, 0, with exactly one transaction between consecutive grants.
- Busy stall: master_spi_busy held high for 20 cycles after the grant → no strobe during those cycles, exactly one strobe after busy falls.
- Requester withdrawal: req 2 drops valid during WAIT → req_done[2] still pulses on tx_done, and no second grant to requester 2.
- Mid-transaction reset: assert rst in WAIT → all outputs 0, rr_ptr = 0, no req_done. A new request is then served normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 50): tx_done withheld → req_done[1] and req_err[1] pulse 50 cycles after entering WAIT, req_rdata = 0, next grant goes to requester 2.
